// File: rtl/vga_pkg.sv
// Shared constants and types for the framebuffer arbiter slice.
//   FB_W/FB_H/FB_WORDS : framebuffer geometry in words
//   SCALE_LOG2         : screen-to-framebuffer downscale shift
//   ADDR_W/COLOR_W     : RAM address and 3:3:3 pixel widths
//   PIPE_LAT           : display path latency (address -> rgb)
package vga_pkg;

  localparam int unsigned FB_W       = 160;
  localparam int unsigned FB_H       = 120;
  localparam int unsigned FB_WORDS   = FB_W * FB_H;
  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned COLOR_W    = 9;
  localparam int unsigned PIPE_LAT   = 3;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } fb_state_t;

  // Control bits carried alongside the display fetch.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_enable;
    logic display_slot;
  } pix_ctl_t;

  // (y'*160 + x') built from shifts: y'*128 + y'*32 + x'.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] px,
                                                input logic [9:0] py);
    logic [ADDR_W-1:0] xs;
    logic [ADDR_W-1:0] ys;
    xs = ADDR_W'(px >> SCALE_LOG2);
    ys = ADDR_W'(py >> SCALE_LOG2);
    return (ys << 7) + (ys << 5) + xs;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value.
//   clock, reset : pixel clock, synchronous active-high reset
//   din          : W-bit value entering the delay line
//   dout         : din delayed by N clocks
module sync_delay #(
  parameter int unsigned     N       = 3,
  parameter int unsigned     W       = 4,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[N-1];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA display fetch, CPU write port and a
// whole-buffer clear engine share one registered RAM port.
//   clock, reset                  : pixel clock, synchronous active-high reset
//   pixel_x/pixel_y/video_enable  : scan position from VGA_sync
//   hsync_in/vsync_in             : raw sync pulses from VGA_sync
//   wr_req/wr_addr/wr_data/wr_ack : CPU write handshake (req held until ack)
//   clear_req/clear_color         : start pulse and fill colour for a clear
//   clear_busy/clear_done         : clear status
//   mem_addr/mem_we/mem_wdata     : registered RAM port
//   mem_rdata                     : RAM read data (1-cycle latency)
//   rgb/hsync_out/vsync_out       : pixel colour and aligned sync pulses
module fb_arbiter
  import vga_pkg::*;
#(
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               video_enable,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORDS     = ADDR_W'(FB_WORDS);

  fb_state_t            state;
  logic [ADDR_W-1:0]    clr_cnt;
  logic [COLOR_W-1:0]   clr_color;
  logic                 display_slot;
  logic [ADDR_W-1:0]    disp_addr;
  pix_ctl_t             ctl_in;
  pix_ctl_t             ctl_d;

  assign display_slot = video_enable && (pixel_x[1:0] == 2'd0);
  assign disp_addr    = fb_addr(pixel_x, pixel_y);

  // Port arbitration and clear engine.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      clr_color  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      wr_ack     <= 1'b0;
      clear_done <= 1'b0;

      if (display_slot) mem_addr <= disp_addr;

      case (state)
        S_IDLE: begin
          // A clear is accepted on any cycle since clear_req is a one-cycle
          // pulse; a CPU write needs a free slot. The !wr_ack term stops the
          // still-held request from being issued twice.
          if (clear_req) begin
            clr_color  <= clear_color;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            state      <= S_CLEAR;
          end else if (!display_slot && wr_req && !wr_ack) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            mem_we    <= (wr_addr < WORDS);
            wr_ack    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (!display_slot) begin
            mem_addr  <= clr_cnt;
            mem_wdata <= clr_color;
            mem_we    <= 1'b1;
            if (clr_cnt == LAST_ADDR) begin
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctl_in = '{hsync: hsync_in, vsync: vsync_in,
                    video_enable: video_enable, display_slot: display_slot};

  // Two delay stages here plus the output registers below give the full
  // three-cycle alignment with rgb; rgb must be decided from the stage that
  // lines up with mem_rdata, one cycle before the outputs.
  sync_delay #(
    .N       (PIPE_LAT - 1),
    .W       (4),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0, 1'b0})
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .din   (ctl_in),
    .dout  (ctl_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb       <= '0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      hsync_out <= ctl_d.hsync;
      vsync_out <= ctl_d.vsync;
      if (!ctl_d.video_enable) rgb <= '0;
      else if (ctl_d.display_slot) rgb <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural RAM.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_enable, hsync_in, vsync_in;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [8:0]  wr_data;
  logic        wr_ack;
  logic        clear_req;
  logic [8:0]  clear_color;
  logic        clear_busy, clear_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [8:0]  mem_wdata, mem_rdata;
  logic [8:0]  rgb;
  logic        hsync_out, vsync_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] ram     [19200];
  logic [8:0] exp_img [19200];

  logic       sync_chk = 1'b0;
  logic [2:0] hs_h, vs_h, ven_h;
  logic [9:0] x_h [3];
  logic [9:0] y_h [3];

  always #5 clk = ~clk;

  fb_arbiter #(.SYNC_IDLE(1'b1)) dut (
    .clock(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_enable(video_enable), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  // Registered single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 9'h000;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference history of driven inputs, oldest in slot 2.
  always @(posedge clk) begin
    if (reset) begin
      hs_h <= 3'b111; vs_h <= 3'b111; ven_h <= 3'b000;
      for (int i = 0; i < 3; i++) begin x_h[i] <= '0; y_h[i] <= '0; end
    end else begin
      hs_h  <= {hs_h[1:0], hsync_in};
      vs_h  <= {vs_h[1:0], vsync_in};
      ven_h <= {ven_h[1:0], video_enable};
      x_h[0] <= pixel_x; x_h[1] <= x_h[0]; x_h[2] <= x_h[1];
      y_h[0] <= pixel_y; y_h[1] <= y_h[0]; y_h[2] <= y_h[1];
    end
  end

  always @(negedge clk) begin
    if (sync_chk) begin
      check("hsync_align", hsync_out, hs_h[2]);
      check("vsync_align", vsync_out, vs_h[2]);
      if (ven_h[2])
        check("rgb_pixel", rgb,
              exp_img[(int'(y_h[2]) / 4) * 160 + int'(x_h[2]) / 4]);
      else
        check("rgb_blank", rgb, 9'h000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y);
    pixel_x      = 10'(x);
    pixel_y      = 10'(y);
    video_enable = (x < 640) && (y < 480);
    hsync_in     = !((x >= 656) && (x < 752));
    vsync_in     = !((y >= 490) && (y < 492));
  endtask

  task automatic sweep(input int ylo, input int yhi);
    sync_chk = 1'b1;
    for (int y = ylo; y <= yhi; y++)
      for (int x = 0; x < 800; x++) begin
        drive_pix(x, y);
        step();
      end
    sync_chk = 1'b0;
    drive_pix(700, 500);
    repeat (3) step();
  endtask

  // Expects blanking; the write must be acked on the first edge.
  task automatic cpu_write(input string tag, input logic [14:0] a,
                           input logic [8:0] d);
    int   n;
    logic acked;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    n = 0; acked = 1'b0;
    while (!acked && n < 8) begin
      step();
      n++;
      acked = wr_ack;
    end
    check({tag, "_ack"}, acked, 1'b1);
    check({tag, "_lat"}, n, 1);
    check({tag, "_we"}, mem_we, (a < 15'd19200));
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_wdata"}, mem_wdata, d);
    wr_req = 1'b0;
    step();
    check({tag, "_ack_pulse"}, wr_ack, 1'b0);
    check({tag, "_no_rewrite"}, mem_we, 1'b0);
    if (a < 15'd19200) exp_img[a] = d;
  endtask

  initial begin : main
    int nwr, addr_err, data_err, ack_err, busy_err, ndone, guard;
    logic busy_at_done, done;

    for (int i = 0; i < 19200; i++) begin ram[i] = '0; exp_img[i] = '0; end
    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    drive_pix(700, 500);
    repeat (3) step();

    check("rst_mem_addr", mem_addr, 15'd0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wdata", mem_wdata, 9'h000);
    check("rst_rgb", rgb, 9'h000);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    check("rst_hsync", hsync_out, 1'b1);
    check("rst_vsync", vsync_out, 1'b1);
    reset = 1'b0;
    step();

    // CPU writes in blanking, including an out-of-range address.
    cpu_write("wr0", 15'd0, 9'h1D5);
    cpu_write("wr161", 15'd161, 9'h0AA);
    cpu_write("wr162", 15'd162, 9'h0F0);
    cpu_write("wr_oor", 15'd19200, 9'h155);

    // Fill readback over the first two framebuffer rows.
    sweep(0, 7);

    // Write contention on a display slot at pixel_x = 8, pixel_y = 4.
    drive_pix(8, 4);
    wr_req = 1'b1; wr_addr = 15'd300; wr_data = 9'h123;
    step();
    check("cont_no_we", mem_we, 1'b0);
    check("cont_disp_addr", mem_addr, 15'd162);
    check("cont_no_ack", wr_ack, 1'b0);
    drive_pix(9, 4);
    step();
    check("cont_ack", wr_ack, 1'b1);
    check("cont_we", mem_we, 1'b1);
    check("cont_wr_addr", mem_addr, 15'd300);
    check("cont_wr_data", mem_wdata, 9'h123);
    wr_req = 1'b0;
    exp_img[300] = 9'h123;
    drive_pix(10, 4);
    step();
    check("cont_rgb", rgb, 9'h0F0);
    drive_pix(11, 4);
    step();
    check("cont_rgb_hold", rgb, 9'h0F0);
    drive_pix(700, 500);
    repeat (3) step();

    // Full clear in blanking with a CPU write held pending.
    clear_req = 1'b1; clear_color = 9'h1FF;
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 9'h000;
    step();
    clear_req = 1'b0; clear_color = 9'h000;
    check("clr_busy", clear_busy, 1'b1);
    check("clr_first_no_ack", wr_ack, 1'b0);
    check("clr_first_no_we", mem_we, 1'b0);
    nwr = 0; addr_err = 0; data_err = 0; ack_err = 0; busy_err = 0;
    ndone = 0; guard = 0; done = 1'b0; busy_at_done = 1'b1;
    while (!done && guard < 25000) begin
      step();
      guard++;
      if (mem_we) begin
        if (mem_addr != 15'(nwr)) addr_err++;
        if (mem_wdata != 9'h1FF) data_err++;
        nwr++;
      end
      if (wr_ack) ack_err++;
      if (clear_done) begin done = 1'b1; ndone++; busy_at_done = clear_busy; end
      else if (!clear_busy) busy_err++;
    end
    check("clr_done_seen", done, 1'b1);
    check("clr_writes", nwr, 19200);
    check("clr_addr_seq_errs", addr_err, 0);
    check("clr_data_errs", data_err, 0);
    check("clr_ack_during", ack_err, 0);
    check("clr_busy_drop", busy_err, 0);
    check("clr_busy_at_done", busy_at_done, 1'b0);
    step();
    check("clr_done_pulse", clear_done, 1'b0);
    check("clr_pend_ack", wr_ack, 1'b1);
    check("clr_pend_we", mem_we, 1'b1);
    check("clr_pend_addr", mem_addr, 15'd5);
    wr_req = 1'b0;
    for (int i = 0; i < 19200; i++) exp_img[i] = 9'h1FF;
    exp_img[5] = 9'h000;
    step();
    check("clr_pend_once", wr_ack, 1'b0);
    sweep(0, 7);

    // Reset while a clear is in progress.
    clear_req = 1'b1; clear_color = 9'h003;
    step();
    clear_req = 1'b0;
    guard = 0;
    while (!(mem_we && mem_addr == 15'd5000) && guard < 25000) begin
      step();
      guard++;
    end
    check("mid_reached_5000", mem_addr, 15'd5000);
    reset = 1'b1;
    step();
    check("mid_rst_addr", mem_addr, 15'd0);
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_wdata", mem_wdata, 9'h000);
    check("mid_rst_busy", clear_busy, 1'b0);
    check("mid_rst_done", clear_done, 1'b0);
    check("mid_rst_ack", wr_ack, 1'b0);
    check("mid_rst_rgb", rgb, 9'h000);
    check("mid_rst_hsync", hsync_out, 1'b1);
    reset = 1'b0;
    ndone = 0; nwr = 0; busy_err = 0;
    repeat (30) begin
      step();
      if (clear_done) ndone++;
      if (mem_we) nwr++;
      if (clear_busy) busy_err++;
    end
    check("mid_no_done", ndone, 0);
    check("mid_no_writes", nwr, 0);
    check("mid_no_busy", busy_err, 0);

    // Sync alignment across the end of the active area and vsync.
    sweep(478, 493);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single port of a 160×120×9-bit framebuffer RAM between the VGA pixel fetch and a CPU write port, and also runs a whole-buffer clear engine. The block sits between `VGA_sync` (pixel clock domain) and the framebuffer RAM. It emits 9-bit RGB and delayed sync pulses aligned to the fetched data. Each framebuffer pixel covers a 4×4 block of screen pixels.

## Interface
- `FB_W`, 160: framebuffer width in words.
- `FB_H`, 120: framebuffer height in words.
- `SCALE_LOG2`, 2: screen-to-framebuffer downscale shift.
- `ADDR_W`, 15: RAM address width.
- `COLOR_W`, 9: pixel width (3:3:3 RGB).
- `SYNC_IDLE`, 1'b1: reset value of `hsync_out`/`vsync_out`.
- `clock` in 1: pixel clock; one clock only.
- `reset` in 1: synchronous, active-high.
- `pixel_x` in 10: current column from `VGA_sync`.
- `pixel_y` in 10: current row from `VGA_sync`.
- `video_enable` in 1: active area flag from `VGA_sync`.
- `hsync_in` in 1: horizontal sync from `VGA_sync`.
- `vsync_in` in 1: vertical sync from `VGA_sync`.
- `wr_req` in 1: CPU write request; must be held until `wr_ack`.
- `wr_addr` in ADDR_W: CPU write address.
- `wr_data` in COLOR_W: CPU write data.
- `wr_ack` out 1: one-cycle pulse when the CPU write is issued.
- `clear_req` in 1: single-cycle pulse that starts a full-buffer clear.
- `clear_color` in COLOR_W: fill value, sampled on the cycle `clear_req` is accepted.
- `clear_busy` out 1: high while a clear is running.
- `clear_done` out 1: one-cycle pulse after the last clear write.
- `mem_addr` out ADDR_W: registered RAM address.
- `mem_we` out 1: registered RAM write enable.
- `mem_wdata` out COLOR_W: registered RAM write data.
- `mem_rdata` in COLOR_W: RAM read data, 1-cycle registered-RAM latency.
- `rgb` out COLOR_W: pixel colour to the DAC.
- `hsync_out` out 1: `hsync_in` delayed to match `rgb`.
- `vsync_out` out 1: `vsync_in` delayed to match `rgb`.

## Operation
- **Display slot.** A cycle with `video_enable && pixel_x[1:0]==0` is a display slot. The display always wins the port in this cycle.
  - Next-edge `mem_addr` = `(pixel_y>>2)*160 + (pixel_x>>2)`, computed as `(y'<<7)+(y'<<5)+x'` at 15 bits. Result range is 0..19199.
  - Next-edge `mem_we` = 0.
- **Free slot.** Every other cycle is a free slot: blanking, or `pixel_x[1:0]!=0`. Free slots are granted in priority order: clear engine, then CPU.
- **FSM.** States are `S_IDLE` and `S_CLEAR`.
  - `S_IDLE`, free slot with `wr_req`=1: issue `mem_we`=1 with `wr_addr`/`wr_data`, and assert `wr_ack` in the same cycle the write is registered.
  - CPU out-of-range address (`wr_addr`≥19200): `wr_ack` is still pulsed, but `mem_we` stays 0 (write dropped).
  - `S_IDLE` + `clear_req`: latch `clear_color`, set the clear counter to 0, and go to `S_CLEAR`. A clear request outranks a simultaneous CPU write, which stays pending.
  - `S_CLEAR`: each free slot writes `clear_color` at the counter address and increments the counter. After the write to 19199, pulse `clear_done`, deassert `clear_busy`, and return to `S_IDLE`.
  - In `S_CLEAR`, `wr_ack` is withheld and `clear_req` is ignored.
- **Pixel output.**
  - `rgb` = `mem_rdata` when the 3-cycle-delayed `video_enable` is 1 and the delayed slot was a display read; otherwise `rgb` holds its value within a 4-pixel group.
  - `rgb` = 0 when the delayed `video_enable` is 0.
- **Sync delay.** `hsync_in`, `vsync_in` and `video_enable` are delayed 3 cycles so they stay aligned with `rgb`.
- **Reset** (including mid-clear):
  - Values: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `rgb`=0, `wr_ack`=0, `clear_busy`=0, `clear_done`=0, `hsync_out`/`vsync_out`=`SYNC_IDLE`, FSM=`S_IDLE`.
  - Delay pipeline is flushed to the inactive state.
  - A clear in progress is aborted with no `clear_done`.

## Timing
- Display path latency is 3 cycles:
  - Edge 1: address is registered.
  - Edge 2: RAM samples the address.
  - Edge 3: `rgb` is registered.
- `hsync_out`/`vsync_out` lag their inputs by exactly 3 cycles.
- CPU write latency: `wr_ack` is asserted at most 4 cycles after `wr_req` during the active area when no clear is running. In blanking it is asserted on the next edge.
- Full clear needs 19200 free slots: about 25.6 k cycles during the active area, and fewer when the clear overlaps blanking.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `vga_pkg` holds:
  - `FB_W`, `FB_H`, `FB_WORDS` (19200), `SCALE_LOG2`, `ADDR_W`, `COLOR_W`, `PIPE_LAT` (3).
  - The FSM state enum.
- Sub-module `sync_delay`: a parameterised N-stage shift register for `{hsync, vsync, video_enable, display_slot}` with a per-bit reset value.

## Test plan
- **Fill readback:** CPU writes 9'h1D5 to address 0 and 9'h0AA to address 161, then run a frame. Expected: `rgb`=9'h1D5 for screen x 0..3, y 0..3; `rgb`=9'h0AA for x 4..7, y 4..7; each appears 3 cycles after its coordinates.
- **Write contention:** assert `wr_req` on a cycle where `pixel_x`=8 and `video_enable`=1. Expected: no write that cycle, `wr_ack` on the next edge, and the display read at address `(y>>2)*160+2` is unaffected.
- **Clear:** pulse `clear_req` with `clear_color`=9'h1FF in blanking. Expected: `clear_busy` high, exactly 19200 writes covering addresses 0..19199, one `clear_done`, and the following frame all 9'h1FF. A `wr_req` held during the clear is acked only after `clear_done`.
- **Out-of-range write:** `wr_addr`=19200. Expected: `wr_ack` pulses and `mem_we` stays 0.
- **Reset mid-clear:** assert `reset` at counter 5000. Expected: all outputs at their reset values next edge, `clear_busy`=0, no `clear_done`.
- **Sync alignment:** across a full 800×525 frame, `hsync_out`/`vsync_out` equal the inputs delayed 3 cycles, and `rgb`=0 whenever the delayed `video_enable` is 0.
